// File: rtl/serial_word_queue.sv
// serial_word_queue: bit-serial receiver that assembles WIDTH-bit words and
// queues them in a DEPTH-entry circular FIFO. Strobes are edge-detected so
// slow, multi-cycle strobes count once.
module serial_word_queue #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit AUTO_ENQ  = 1'b0
) (
  input  logic                       clock_1MHz,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  output logic                       status_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out,
  output logic                       underflow_out
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {INIT, RECV, HOLD} state_t;
  state_t state, next_state;

  logic             write_q, enq_q, deq_q;
  logic             write_evt, enq_evt, deq_evt;
  logic [BW-1:0]    bit_cnt, pos;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             capture, last_bit, push_req, push, pop, ovf;

  assign write_evt = write_in & ~write_q;
  assign enq_evt   = enqueue_in & ~enq_q;
  assign deq_evt   = dequeue_in & ~deq_q;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A pop in the same cycle frees a slot, so a push against a full FIFO may proceed.
  assign pop      = deq_evt & ~empty;
  assign last_bit = (bit_cnt == BW'(WIDTH-1));
  assign pos      = LSB_FIRST ? bit_cnt : (BW'(WIDTH-1) - bit_cnt);
  assign push_req = AUTO_ENQ ? 1'b1 : enq_evt;

  assign status_out = (state == RECV);
  assign count_out  = count;
  assign full_out   = full;
  assign empty_out  = empty;

  // Strobe history for rising-edge detection.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
    end else begin
      write_q <= write_in;
      enq_q   <= enqueue_in;
      deq_q   <= dequeue_in;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Receiver next-state and push/overflow decisions.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    push       = 1'b0;
    ovf        = 1'b0;
    case (state)
      INIT: next_state = RECV;
      RECV: begin
        if (write_evt) begin
          capture = 1'b1;
          if (last_bit) next_state = HOLD;
        end
      end
      HOLD: begin
        if (push_req) begin
          if (!full || pop) begin
            push       = 1'b1;
            next_state = RECV;
          end else begin
            ovf = ~AUTO_ENQ;
          end
        end
      end
      default: next_state = INIT;
    endcase
  end

  // Bit assembly: place each captured bit and advance the bit counter.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (capture) begin
      shreg[pos] <= data_in;
      bit_cnt    <= last_bit ? '0 : bit_cnt + BW'(1);
    end
  end

  // FIFO storage; contents need no reset since count guards reads.
  always_ff @(posedge clock_1MHz) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, popped word and error pulses.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow_out  <= ovf;
      underflow_out <= deq_evt & empty;
    end
  end
endmodule

// File: tb/tb_serial_word_queue.sv
// Directed bench: default instance (LSB first, manual enqueue) plus an
// MSB-first auto-enqueue instance for the bit-order variant.
`timescale 1ns/1ps
module tb_serial_word_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, wr = 1'b0, enq = 1'b0, deq = 1'b0;
  logic       status, full, empty, ovf, unf;
  logic [7:0] data;
  logic [3:0] count;
  logic       din2 = 1'b0, wr2 = 1'b0, enq2 = 1'b0, deq2 = 1'b0;
  logic       status2, full2, empty2, ovf2, unf2;
  logic [7:0] data2;
  logic [3:0] count2;
  int         n_checks = 0, n_fail = 0;
  int         ovf_cnt = 0, unf_cnt = 0;

  always #500 clk = ~clk;

  serial_word_queue dut (
    .clock_1MHz(clk), .rst(rst), .data_in(din), .write_in(wr),
    .enqueue_in(enq), .dequeue_in(deq), .status_out(status),
    .data_out(data), .count_out(count), .full_out(full),
    .empty_out(empty), .overflow_out(ovf), .underflow_out(unf));

  serial_word_queue #(.WIDTH(8), .DEPTH(8), .LSB_FIRST(1'b0), .AUTO_ENQ(1'b1)) dut2 (
    .clock_1MHz(clk), .rst(rst), .data_in(din2), .write_in(wr2),
    .enqueue_in(enq2), .dequeue_in(deq2), .status_out(status2),
    .data_out(data2), .count_out(count2), .full_out(full2),
    .empty_out(empty2), .overflow_out(ovf2), .underflow_out(unf2));

  // Count high cycles of the error pulses on the first instance.
  always @(negedge clk) begin
    if (ovf) ovf_cnt++;
    if (unf) unf_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int which, input logic b, input int hi, input int lo);
    if (which == 0) begin din = b; wr = 1'b1; end
    else begin din2 = b; wr2 = 1'b1; end
    tick(hi);
    wr = 1'b0; wr2 = 1'b0;
    tick(lo);
  endtask

  // Bits go out in time order b0, b1, ... b7.
  task automatic send_word(input int which, input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(which, w[i], 3, 3);
  endtask

  // which: 0 enqueue, 1 dequeue, 2 dequeue on second instance
  task automatic pulse(input int which);
    case (which)
      0: enq = 1'b1;
      1: deq = 1'b1;
      default: deq2 = 1'b1;
    endcase
    tick(3);
    enq = 1'b0; deq = 1'b0; deq2 = 1'b0;
    tick(3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
    n_checks++; if ({status, full, empty, ovf, unf} !== 5'b00100) begin n_fail++; $display("FAIL reset_flags got %b want 00100", {status, full, empty, ovf, unf}); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    rst = 1'b0;
    n_checks++; if (status !== 1'b0) begin n_fail++; $display("FAIL status_at_release got %b want 0", status); end
    tick(1);
    n_checks++; if (status !== 1'b1) begin n_fail++; $display("FAIL status_after_release got %b want 1", status); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_after_release got %b want 1", empty); end
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'hAA;
    for (int i = 0; i < 7; i++) send_bit(0, w[i], 10, 10);
    n_checks++; if (status !== 1'b1) begin n_fail++; $display("FAIL status_7bits got %b want 1", status); end
    send_bit(0, w[7], 10, 10);
    n_checks++; if (status !== 1'b0) begin n_fail++; $display("FAIL status_8bits got %b want 0", status); end
    pulse(0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", count); end
    n_checks++; if (status !== 1'b1) begin n_fail++; $display("FAIL basic_status got %b want 1", status); end
    pulse(1);
    n_checks++; if (data !== 8'hAA) begin n_fail++; $display("FAIL basic_data got %h want aa", data); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
  endtask

  task automatic test_fill;
    int o0;
    for (int i = 1; i <= 8; i++) begin send_word(0, 8'(i)); pulse(0); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", count); end
    send_word(0, 8'h09);
    o0 = ovf_cnt;
    pulse(0);
    n_checks++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL overflow_pulse got %0d cycles want 1", ovf_cnt - o0); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL overflow_count got %0d want 8", count); end
    n_checks++; if (status !== 1'b0) begin n_fail++; $display("FAIL overflow_status got %b want 0", status); end
    for (int i = 1; i <= 8; i++) begin
      pulse(1);
      n_checks++; if (data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, data, 8'(i)); end
    end
  endtask

  task automatic test_underflow;
    int u0;
    u0 = unf_cnt;
    pulse(1);
    n_checks++; if (unf_cnt - u0 !== 1) begin n_fail++; $display("FAIL underflow_pulse got %0d cycles want 1", unf_cnt - u0); end
    n_checks++; if (data !== 8'h08) begin n_fail++; $display("FAIL underflow_data got %h want 08", data); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL underflow_count got %0d want 0", count); end
  endtask

  task automatic test_simultaneous;
    int o0, u0;
    // 0x09 is still held from the overflow attempt.
    pulse(0);
    for (int i = 10; i <= 16; i++) begin send_word(0, 8'(i)); pulse(0); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL simul_pre_count got %0d want 8", count); end
    send_word(0, 8'h11);
    o0 = ovf_cnt;
    enq = 1'b1; deq = 1'b1;
    tick(3);
    enq = 1'b0; deq = 1'b0;
    tick(3);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL simul_count got %0d want 8", count); end
    n_checks++; if (ovf_cnt !== o0) begin n_fail++; $display("FAIL simul_overflow got %0d cycles want 0", ovf_cnt - o0); end
    n_checks++; if (data !== 8'h09) begin n_fail++; $display("FAIL simul_data got %h want 09", data); end
    n_checks++; if (status !== 1'b1) begin n_fail++; $display("FAIL simul_status got %b want 1", status); end
    for (int i = 10; i <= 17; i++) begin
      pulse(1);
      n_checks++; if (data !== 8'(i)) begin n_fail++; $display("FAIL simul_drain[%0d] got %h want %h", i, data, 8'(i)); end
    end
    // Empty FIFO: pop underflows, push still lands.
    send_word(0, 8'h77);
    u0 = unf_cnt;
    enq = 1'b1; deq = 1'b1;
    tick(3);
    enq = 1'b0; deq = 1'b0;
    tick(3);
    n_checks++; if (unf_cnt - u0 !== 1) begin n_fail++; $display("FAIL empty_simul_underflow got %0d want 1", unf_cnt - u0); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL empty_simul_count got %0d want 1", count); end
    n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL empty_simul_data got %h want 11", data); end
    pulse(1);
    n_checks++; if (data !== 8'h77) begin n_fail++; $display("FAIL empty_simul_pop got %h want 77", data); end
  endtask

  task automatic test_reset_mid;
    send_bit(0, 1'b1, 3, 3); send_bit(0, 1'b0, 3, 3); send_bit(0, 1'b1, 3, 3);
    rst = 1'b1;
    tick(2);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h want 00", data); end
    rst = 1'b0;
    tick(2);
    send_word(0, 8'h5C);
    pulse(0);
    pulse(1);
    n_checks++; if (data !== 8'h5C) begin n_fail++; $display("FAIL midreset_word got %h want 5c", data); end
    // Same sequence on the MSB-first auto-enqueue instance.
    send_bit(1, 1'b1, 3, 3); send_bit(1, 1'b0, 3, 3); send_bit(1, 1'b1, 3, 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_word(1, 8'h5C);
    n_checks++; if (count2 !== 4'd1) begin n_fail++; $display("FAIL auto_count got %0d want 1", count2); end
    n_checks++; if (status2 !== 1'b1) begin n_fail++; $display("FAIL auto_status got %b want 1", status2); end
    pulse(2);
    n_checks++; if (data2 !== 8'h3A) begin n_fail++; $display("FAIL msb_first_word got %h want 3a", data2); end
    n_checks++; if (empty2 !== 1'b1) begin n_fail++; $display("FAIL auto_empty got %b want 1", empty2); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_underflow;
    test_simultaneous;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
